draw_block_pipe: RTL and testbench
==================================

Name: draw_block_pipe

Overview:
- Registered, parametrised successor to the combinational block-field renderer for the VGA playfield.
- Per pixel: computes cell row/col, presents it as an address to the synchronous block memory, then colours the pixel from the returned 3-bit block code.
- Adds a hit-flash animation: the most recently hit cell blinks white for a programmable number of frames.
- Sits between the VGA counters and the pixel colour mux; the mux compensates for the fixed 3-cycle latency.

Parameters:
- LEFT, 160, first playfield pixel column
- TOP, 0, first playfield pixel row
- COLS, 10, cells per row
- ROWS, 30, cell rows
- CELL_W, 32, cell width in pixels (power of two, >=8)
- CELL_H, 16, cell height in pixels (power of two, >=2)
- COL_W, 5, sel_col/hit_col width
- ROW_W, 5, sel_row/hit_row width
- FLASH_FRAMES, 8, frames a hit cell blinks (1..255)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset, asynchronous, active-low
- hcounter  in  12  VGA horizontal counter
- vcounter  in  11  VGA vertical counter
- frame_start  in  1  one-cycle pulse at the start of each frame
- hit_valid  in  1  one-cycle pulse: a block was hit
- hit_row  in  ROW_W  row of the hit cell
- hit_col  in  COL_W  column of the hit cell
- sel_row  out  ROW_W  registered block-memory row address
- sel_col  out  COL_W  registered block-memory column address
- block  in  3  block code returned by memory, valid the cycle after sel_* are presented
- out  out  4  registered pixel colour

Behaviour:
- Clock and reset: single clock. Reset is asynchronous and active-low. Clock port is clk, reset port is rst_n.
- Reset values: sel_row=0, sel_col=0, out=0, pipeline context=0, flash_cnt=0 (flash inactive), flash row/col=0.
- Range check: the pixel is in range when LEFT <= hcounter < LEFT+COLS*CELL_W and TOP <= vcounter < TOP+ROWS*CELL_H.
- Cell decode: col = (hcounter-LEFT)>>log2(CELL_W); row = (vcounter-TOP)>>log2(CELL_H). In-cell offsets: i = low log2(CELL_W) bits, j = low log2(CELL_H) bits. No divider is permitted.
- Stage 1, edge t+1: register sel_row/sel_col. Both are forced to 0 when the pixel is out of range. Also register the context {range, i, j}.
- Stage 2, edge t+2: memory latches its address. The block code is valid during cycle t+2. Context is delayed one more stage.
- Stage 3, edge t+3: register out. Latency from counters to out is exactly 3 edges.
- Colour rules, with Q=CELL_W/4:
  - Out of range, or code 0: out=0000.
  - Codes 1-3 (narrow block):
    - i==Q or i==3Q-1: border, 1000.
    - Q<i<3Q-1 with j==0 or j==CELL_H-1: border, 1000.
    - Q<i<3Q-1 otherwise: body colour, 1->1100, 2->1110, 3->1101.
    - Any other i: 0000.
  - Codes 4-7 (full block):
    - i==0, i==CELL_W-1, j==0 or j==CELL_H-1: border, 1000.
    - Otherwise body colour: 4->1001, 5->1011, 6->1010, 7->1111.
- Flash state machine:
  - States: IDLE (flash_cnt==0) and FLASH (flash_cnt>0).
  - hit_valid: latch hit_row/hit_col and load flash_cnt=FLASH_FRAMES. This applies in any state and restarts any active flash.
  - frame_start while in FLASH: decrement flash_cnt; reaching 0 returns to IDLE.
  - hit_valid and frame_start in the same cycle: the load wins and no decrement occurs.
  - frame_start while IDLE: no effect.
- Flash override:
  - Applies in stage 3 when the pipelined cell matches the latched flash cell, the pixel is in range, and flash_cnt[0]==1.
  - The whole cell is driven to 1111, regardless of block code (code 0 included, so an erased block stays visible while flashing).
  - When flash_cnt[0]==0, normal rendering applies.
- Flash inputs are compared against the pipelined row/col, so a mid-frame hit affects only pixels reaching stage 3 after the load.
- Reset asserted mid-frame: all registers clear immediately. After release, out is valid once the pipeline refills, on the 3rd edge.

Test Plan:
- Reset with rst_n=0 mid-stream -> out=0, sel_row=0, sel_col=0 asynchronously, before the next clk edge.
- hcounter=200, vcounter=40 with memory model returning 5 -> sel_col=1, sel_row=2 after 1 edge; out=1011 after 3 edges. Same row/col at hcounter=192 (i=0) -> out=1000.
- Narrow block, code 2, cell (0,0), j=5: hcounter=168 -> 1000; 170 -> 1110; 183 -> 1000; 190 -> 0000. hcounter=170, vcounter=0 -> 1000.
- Out of range: hcounter=159 or 480, or vcounter=480 -> out=0000 and sel_row=sel_col=0.
- Flash, FLASH_FRAMES=3: hit_valid with row=1, col=2 -> cell pixels read 1111 for frames with cnt=3 and 1, normal for cnt=2, normal after the third frame_start. Code 0 in the flashing cell -> 1111 on odd counts.
- Simultaneous hit_valid and frame_start with cnt=1 -> cnt reloads to FLASH_FRAMES, and the new coordinates take effect.

Source files
------------

// File: rtl/draw_block_pipe.sv
// Pipelined playfield block renderer: counters -> block-memory address -> pixel colour,
// with a blinking white flash on the most recently hit cell. Fixed 3-cycle latency.
module draw_block_pipe #(
    parameter int unsigned LEFT         = 160,
    parameter int unsigned TOP          = 0,
    parameter int unsigned COLS         = 10,
    parameter int unsigned ROWS         = 30,
    parameter int unsigned CELL_W       = 32,
    parameter int unsigned CELL_H       = 16,
    parameter int unsigned COL_W        = 5,
    parameter int unsigned ROW_W        = 5,
    parameter int unsigned FLASH_FRAMES = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [11:0]      hcounter,
    input  logic [10:0]      vcounter,
    input  logic             frame_start,
    input  logic             hit_valid,
    input  logic [ROW_W-1:0] hit_row,
    input  logic [COL_W-1:0] hit_col,
    output logic [ROW_W-1:0] sel_row,
    output logic [COL_W-1:0] sel_col,
    input  logic [2:0]       block,
    output logic [3:0]       out
);

    localparam int unsigned IW = $clog2(CELL_W);
    localparam int unsigned JW = $clog2(CELL_H);
    localparam int unsigned Q  = CELL_W / 4;

    localparam logic [11:0]   H_LO   = 12'(LEFT);
    localparam logic [11:0]   H_SPAN = 12'(COLS * CELL_W);
    localparam logic [10:0]   V_LO   = 11'(TOP);
    localparam logic [10:0]   V_SPAN = 11'(ROWS * CELL_H);
    localparam logic [IW-1:0] I_Q    = IW'(Q);
    localparam logic [IW-1:0] I_Q3   = IW'(3 * Q - 1);
    localparam logic [IW-1:0] I_MAX  = IW'(CELL_W - 1);
    localparam logic [JW-1:0] J_MAX  = JW'(CELL_H - 1);
    localparam logic [7:0]    FLASH_LOAD = 8'(FLASH_FRAMES);

    typedef enum logic [0:0] {IDLE = 1'b0, FLASH = 1'b1} flash_state_t;

    logic [11:0]      h_off;
    logic [10:0]      v_off;
    logic             in_range;
    logic [ROW_W-1:0] row_d;
    logic [COL_W-1:0] col_d;

    logic [ROW_W-1:0] sel_row_q, s2_row_q;
    logic [COL_W-1:0] sel_col_q, s2_col_q;
    logic             s1_range_q, s2_range_q;
    logic [IW-1:0]    s1_i_q, s2_i_q;
    logic [JW-1:0]    s1_j_q, s2_j_q;
    logic [3:0]       out_q, out_d;

    flash_state_t     state_q, state_d;
    logic [7:0]       flash_cnt_q, flash_cnt_d;
    logic [ROW_W-1:0] flash_row_q, flash_row_d;
    logic [COL_W-1:0] flash_col_q, flash_col_d;
    logic             flash_hit;

    // Unsigned wrap makes a single compare cover both bounds of each axis.
    always_comb begin
        h_off    = hcounter - H_LO;
        v_off    = vcounter - V_LO;
        in_range = (h_off < H_SPAN) && (v_off < V_SPAN);
        row_d    = in_range ? ROW_W'(v_off >> JW) : '0;
        col_d    = in_range ? COL_W'(h_off >> IW) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_row_q  <= '0;
            sel_col_q  <= '0;
            s1_range_q <= 1'b0;
            s1_i_q     <= '0;
            s1_j_q     <= '0;
            s2_row_q   <= '0;
            s2_col_q   <= '0;
            s2_range_q <= 1'b0;
            s2_i_q     <= '0;
            s2_j_q     <= '0;
            out_q      <= '0;
        end else begin
            sel_row_q  <= row_d;
            sel_col_q  <= col_d;
            s1_range_q <= in_range;
            s1_i_q     <= h_off[IW-1:0];
            s1_j_q     <= v_off[JW-1:0];
            s2_row_q   <= sel_row_q;
            s2_col_q   <= sel_col_q;
            s2_range_q <= s1_range_q;
            s2_i_q     <= s1_i_q;
            s2_j_q     <= s1_j_q;
            out_q      <= out_d;
        end
    end

    assign flash_hit = s2_range_q && flash_cnt_q[0] &&
                       (s2_row_q == flash_row_q) && (s2_col_q == flash_col_q);

    // Stage 3 colour: block code arrives from memory while stage-2 context is current.
    always_comb begin
        out_d = 4'b0000;
        if (s2_range_q && block != 3'd0) begin
            if (!block[2]) begin
                if (s2_i_q == I_Q || s2_i_q == I_Q3) begin
                    out_d = 4'b1000;
                end else if (s2_i_q > I_Q && s2_i_q < I_Q3) begin
                    if (s2_j_q == '0 || s2_j_q == J_MAX) begin
                        out_d = 4'b1000;
                    end else begin
                        case (block[1:0])
                            2'd1:    out_d = 4'b1100;
                            2'd2:    out_d = 4'b1110;
                            default: out_d = 4'b1101;
                        endcase
                    end
                end
            end else if (s2_i_q == '0 || s2_i_q == I_MAX ||
                         s2_j_q == '0 || s2_j_q == J_MAX) begin
                out_d = 4'b1000;
            end else begin
                case (block[1:0])
                    2'd0:    out_d = 4'b1001;
                    2'd1:    out_d = 4'b1011;
                    2'd2:    out_d = 4'b1010;
                    default: out_d = 4'b1111;
                endcase
            end
        end
        if (flash_hit) begin
            out_d = 4'b1111;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            flash_cnt_q <= '0;
            flash_row_q <= '0;
            flash_col_q <= '0;
        end else begin
            state_q     <= state_d;
            flash_cnt_q <= flash_cnt_d;
            flash_row_q <= flash_row_d;
            flash_col_q <= flash_col_d;
        end
    end

    // A hit always reloads and wins over a coincident frame_start.
    always_comb begin
        state_d     = state_q;
        flash_cnt_d = flash_cnt_q;
        flash_row_d = flash_row_q;
        flash_col_d = flash_col_q;
        if (hit_valid) begin
            flash_cnt_d = FLASH_LOAD;
            flash_row_d = hit_row;
            flash_col_d = hit_col;
            state_d     = FLASH;
        end else if (state_q == FLASH && frame_start) begin
            flash_cnt_d = flash_cnt_q - 8'd1;
            state_d     = (flash_cnt_q == 8'd1) ? IDLE : FLASH;
        end
    end

    assign sel_row = sel_row_q;
    assign sel_col = sel_col_q;
    assign out     = out_q;

endmodule

// File: tb/tb_draw_block_pipe.sv
// Scoreboard bench for draw_block_pipe: driver queues expected results, monitor checks
// sel_* one edge and out three edges after each marked stimulus.
module tb_draw_block_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] hcounter;
    logic [10:0] vcounter;
    logic        frame_start, hit_valid;
    logic [4:0]  hit_row, sel_row;
    logic [4:0]  hit_col, sel_col;
    logic [2:0]  block;
    logic [3:0]  out;

    draw_block_pipe #(.FLASH_FRAMES(3)) dut (
        .clk(clk), .rst_n(rst_n), .hcounter(hcounter), .vcounter(vcounter),
        .frame_start(frame_start), .hit_valid(hit_valid), .hit_row(hit_row),
        .hit_col(hit_col), .sel_row(sel_row), .sel_col(sel_col), .block(block), .out(out)
    );

    always #5 clk = ~clk;

    logic [2:0] mem [0:29][0:9];
    always @(posedge clk) block <= mem[sel_row][sel_col];

    typedef struct packed {
        logic [3:0]  o;
        logic [4:0]  r;
        logic [4:0]  c;
        logic [15:0] id;
    } exp_t;

    exp_t sel_q[$];
    exp_t out_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   next_id  = 0;
    logic stim_v   = 1'b0;
    logic [2:0] vpipe;

    task automatic check(input string name, input int id, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s #%0d: got %0d, expected %0d", name, id, act, req);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) vpipe <= '0;
        else        vpipe <= {vpipe[1:0], stim_v};
    end

    // Monitor: marked stimulus shows on sel_* after one edge and on out after three.
    always @(negedge clk) begin
        if (rst_n) begin
            if (vpipe[0]) begin
                if (sel_q.size() == 0) check("sel_queue_empty", 0, 1, 0);
                else begin
                    exp_t e;
                    e = sel_q.pop_front();
                    check("sel_row", int'(e.id), int'(sel_row), int'(e.r));
                    check("sel_col", int'(e.id), int'(sel_col), int'(e.c));
                end
            end
            if (vpipe[2]) begin
                if (out_q.size() == 0) check("out_queue_empty", 0, 1, 0);
                else begin
                    exp_t e;
                    e = out_q.pop_front();
                    check("out", int'(e.id), int'(out), int'(e.o));
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic apply(input int h, input int v, input logic [3:0] o,
                         input int r, input int c);
        exp_t e;
        hcounter = 12'(h);
        vcounter = 11'(v);
        e.o  = o;
        e.r  = 5'(r);
        e.c  = 5'(c);
        e.id = 16'(next_id);
        next_id++;
        sel_q.push_back(e);
        out_q.push_back(e);
        stim_v = 1'b1;
        @(posedge clk); #1;
        stim_v = 1'b0;
    endtask

    task automatic pulse(input logic hv, input logic fs, input int r, input int c);
        hit_valid   = hv;
        frame_start = fs;
        hit_row     = 5'(r);
        hit_col     = 5'(c);
        @(posedge clk); #1;
        hit_valid   = 1'b0;
        frame_start = 1'b0;
        idle(3);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 10; c++)
                mem[r][c] = 3'd0;
        mem[2][1] = 3'd5;
        mem[0][0] = 3'd2;
        mem[1][3] = 3'd1;
        mem[4][0] = 3'd6;
        mem[1][2] = 3'd0;

        rst_n = 1'b0; hit_valid = 1'b0; frame_start = 1'b0;
        hit_row = '0; hit_col = '0;
        hcounter = 12'd200; vcounter = 11'd40;
        #22;
        check("reset_out", 0, int'(out), 0);
        check("reset_sel_row", 0, int'(sel_row), 0);
        check("reset_sel_col", 0, int'(sel_col), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        // Full block code 5 at cell (2,1): body and left border.
        apply(200, 40, 4'b1011, 2, 1);
        apply(192, 40, 4'b1000, 2, 1);
        apply(223, 40, 4'b1000, 2, 1);
        apply(200, 32, 4'b1000, 2, 1);
        apply(200, 47, 4'b1000, 2, 1);
        // Narrow block code 2 at cell (0,0).
        apply(168, 5, 4'b1000, 0, 0);
        apply(170, 5, 4'b1110, 0, 0);
        apply(183, 5, 4'b1000, 0, 0);
        apply(190, 5, 4'b0000, 0, 0);
        apply(170, 0, 4'b1000, 0, 0);
        apply(268, 21, 4'b1100, 1, 3);
        apply(170, 72, 4'b1010, 4, 0);
        // Out of range on every side.
        apply(159, 40, 4'b0000, 0, 0);
        apply(480, 40, 4'b0000, 0, 0);
        apply(200, 480, 4'b0000, 0, 0);
        idle(4);

        // Asynchronous reset with a non-zero pixel held in the pipe.
        apply(200, 40, 4'b1011, 2, 1);
        idle(4);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_out", 1, int'(out), 0);
        check("async_reset_sel_row", 1, int'(sel_row), 0);
        check("async_reset_sel_col", 1, int'(sel_col), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        apply(200, 40, 4'b1011, 2, 1);
        idle(4);

        // Flash on cell (1,2), code 0: white only on odd counts.
        apply(234, 19, 4'b0000, 1, 2);
        idle(4);
        pulse(1'b1, 1'b0, 1, 2);                    // cnt=3
        apply(234, 19, 4'b1111, 1, 2);
        apply(268, 21, 4'b1100, 1, 3);
        idle(4);
        pulse(1'b0, 1'b1, 0, 0);                    // cnt=2
        apply(234, 19, 4'b0000, 1, 2);
        idle(4);
        pulse(1'b0, 1'b1, 0, 0);                    // cnt=1
        apply(234, 19, 4'b1111, 1, 2);
        idle(4);
        pulse(1'b0, 1'b1, 0, 0);                    // cnt=0
        apply(234, 19, 4'b0000, 1, 2);
        idle(4);
        pulse(1'b0, 1'b1, 0, 0);                    // idle, stays 0
        apply(234, 19, 4'b0000, 1, 2);
        idle(4);

        // Reach cnt=1, then hit and frame_start together: reload to 3 at new cell.
        pulse(1'b1, 1'b0, 1, 2);
        pulse(1'b0, 1'b1, 0, 0);
        pulse(1'b0, 1'b1, 0, 0);
        apply(234, 19, 4'b1111, 1, 2);
        idle(4);
        pulse(1'b1, 1'b1, 4, 0);                    // cnt=3 at (4,0)
        apply(234, 19, 4'b0000, 1, 2);
        apply(170, 72, 4'b1111, 4, 0);
        idle(4);
        pulse(1'b0, 1'b1, 0, 0);                    // cnt=2
        apply(170, 72, 4'b1010, 4, 0);
        idle(5);

        check("sel_queue_drained", 2, sel_q.size(), 0);
        check("out_queue_drained", 2, out_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
